// File: rtl/router_top.sv
// router_top: 1-to-3 byte-serial packet router. Ingress FSM steers header/payload/parity
// into one of three 16-deep FIFOs; each port drains independently with a soft-reset timeout.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// WAIT_TILL_EMPTY    | header latched, destination FIFO still holds an older packet
// LOAD_FIRST_DATA    | write latched header (flagged) into destination FIFO
// LOAD_DATA          | accept payload bytes; parity byte arrives with pkt_valid low
// FIFO_FULL_STATE    | destination full, byte held, stall source
// LOAD_AFTER_FULL    | write the held byte once space is available
// LOAD_PARITY        | finish the parity write (retry while full)
// CHECK_PARITY_ERROR | compare computed vs received parity
module router_top #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SOFT_TMO   = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb_0,
  input  logic              read_enb_1,
  input  logic              read_enb_2,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic              vld_out_0,
  output logic              vld_out_1,
  output logic              vld_out_2,
  output logic              busy,
  output logic              error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = DATA_W - 1;
  localparam int TW = $clog2(SOFT_TMO + 1);
  localparam int NP = 3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] int_par_q, int_par_d;
  logic [DATA_W-1:0] rx_par_q, rx_par_d;
  logic [1:0]        dest_q, dest_d;
  logic              par_got_q, par_got_d;
  logic              par_wr_q, par_wr_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic [DATA_W:0]   mem_q [NP][FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q [NP];
  logic [AW:0]       wr_ptr_d [NP];
  logic [AW:0]       rd_ptr_q [NP];
  logic [AW:0]       rd_ptr_d [NP];
  logic [DATA_W-1:0] dout_q [NP];
  logic [DATA_W-1:0] dout_d [NP];
  logic [CW-1:0]     cnt_q [NP];
  logic [CW-1:0]     cnt_d [NP];
  logic [TW-1:0]     tmo_q [NP];
  logic [TW-1:0]     tmo_d [NP];
  logic [DATA_W:0]   rd_entry [NP];

  logic [NP-1:0]     rd_en, empty, full, flush, wr_port, pop;
  logic              wr_en;
  logic [DATA_W:0]   wr_data;
  logic              dest_empty, dest_full, dest_flush, in_empty;

  always_comb begin
    rd_en = {read_enb_2, read_enb_1, read_enb_0};
    for (int p = 0; p < NP; p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][AW] != rd_ptr_q[p][AW]) &&
                 (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
      // timeout fires on the last stalled clock of the window
      flush[p] = !empty[p] && !rd_en[p] && (tmo_q[p] == TW'(1));
    end
  end

  always_comb begin
    dest_empty = empty[0];
    dest_full  = full[0];
    dest_flush = flush[0];
    in_empty   = empty[0];
    case (dest_q)
      2'd1: begin dest_empty = empty[1]; dest_full = full[1]; dest_flush = flush[1]; end
      2'd2: begin dest_empty = empty[2]; dest_full = full[2]; dest_flush = flush[2]; end
      default: ;
    endcase
    case (data_in[1:0])
      2'd1: in_empty = empty[1];
      2'd2: in_empty = empty[2];
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    hold_d    = hold_q;
    int_par_d = int_par_q;
    rx_par_d  = rx_par_q;
    dest_d    = dest_q;
    par_got_d = par_got_q;
    par_wr_d  = par_wr_q;
    error_d   = error_q;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && data_in[1:0] != 2'd3) begin
          hdr_d     = data_in;
          dest_d    = data_in[1:0];
          int_par_d = data_in;
          error_d   = 1'b0;
          par_got_d = 1'b0;
          par_wr_d  = 1'b0;
          state_d   = in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (dest_empty) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        wr_en   = 1'b1;
        wr_data = {1'b1, hdr_q};
        state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (pkt_valid) begin
          int_par_d = int_par_q ^ data_in;
          if (dest_full) begin
            hold_d  = data_in;
            state_d = FIFO_FULL_STATE;
          end else begin
            wr_en   = 1'b1;
            wr_data = {1'b0, data_in};
          end
        end else begin
          rx_par_d  = data_in;
          par_got_d = 1'b1;
          if (!dest_full) begin
            wr_en    = 1'b1;
            wr_data  = {1'b0, data_in};
            par_wr_d = 1'b1;
          end
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        // par_wr_q set means the packet is complete; only wait for space
        if (!dest_full) state_d = par_wr_q ? DECODE_ADDRESS : LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        wr_en   = 1'b1;
        wr_data = {1'b0, hold_q};
        state_d = pkt_valid ? LOAD_DATA : LOAD_PARITY;
      end
      LOAD_PARITY: begin
        // entered from LOAD_AFTER_FULL the parity byte is still on data_in
        if (!par_got_q) begin
          rx_par_d  = data_in;
          par_got_d = 1'b1;
        end
        if (par_wr_q) begin
          state_d = CHECK_PARITY_ERROR;
        end else if (!dest_full) begin
          wr_en    = 1'b1;
          wr_data  = {1'b0, par_got_q ? rx_par_q : data_in};
          par_wr_d = 1'b1;
          state_d  = CHECK_PARITY_ERROR;
        end
      end
      CHECK_PARITY_ERROR: begin
        error_d = (int_par_q != rx_par_q);
        state_d = dest_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    if (dest_flush && state_q != DECODE_ADDRESS && state_q != WAIT_TILL_EMPTY) begin
      state_d = DECODE_ADDRESS;
      wr_en   = 1'b0;
    end
    busy_d = !(state_d == DECODE_ADDRESS || state_d == LOAD_DATA);
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_entry[p] = mem_q[p][rd_ptr_q[p][AW-1:0]];
      wr_port[p]  = wr_en && (dest_q == 2'(p)) && !flush[p];
      pop[p]      = rd_en[p] && !empty[p];
      wr_ptr_d[p] = wr_ptr_q[p] + (AW+1)'(wr_port[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + (AW+1)'(pop[p]);
      dout_d[p]   = dout_q[p];
      cnt_d[p]    = cnt_q[p];
      if (pop[p]) begin
        dout_d[p] = rd_entry[p][DATA_W-1:0];
        if (rd_entry[p][DATA_W]) cnt_d[p] = {1'b0, rd_entry[p][DATA_W-1:2]} + CW'(1);
        else if (cnt_q[p] != '0) cnt_d[p] = cnt_q[p] - CW'(1);
      end
      tmo_d[p] = TW'(SOFT_TMO);
      if (!empty[p] && !rd_en[p] && !flush[p]) tmo_d[p] = tmo_q[p] - TW'(1);
      if (flush[p]) begin
        wr_ptr_d[p] = '0;
        rd_ptr_d[p] = '0;
        dout_d[p]   = '0;
        cnt_d[p]    = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DECODE_ADDRESS;
      hdr_q     <= '0;
      hold_q    <= '0;
      int_par_q <= '0;
      rx_par_q  <= '0;
      dest_q    <= '0;
      par_got_q <= 1'b0;
      par_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        dout_q[p]   <= '0;
        cnt_q[p]    <= '0;
        tmo_q[p]    <= TW'(SOFT_TMO);
      end
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      hold_q    <= hold_d;
      int_par_q <= int_par_d;
      rx_par_q  <= rx_par_d;
      dest_q    <= dest_d;
      par_got_q <= par_got_d;
      par_wr_q  <= par_wr_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        dout_q[p]   <= dout_d[p];
        cnt_q[p]    <= cnt_d[p];
        tmo_q[p]    <= tmo_d[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int p = 0; p < NP; p++) begin
      if (wr_port[p]) mem_q[p][wr_ptr_q[p][AW-1:0]] <= wr_data;
    end
  end

  assign data_out_0 = dout_q[0];
  assign data_out_1 = dout_q[1];
  assign data_out_2 = dout_q[2];
  assign vld_out_0  = !empty[0];
  assign vld_out_1  = !empty[1];
  assign vld_out_2  = !empty[2];
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_router_top.sv
// Directed + randomized bench for router_top; expected bytes come from a packet-level
// model (header, payload, XOR parity) kept in a queue.
module tb_router_top;
  logic       clock = 1'b0;
  logic       resetn, pkt_valid;
  logic [7:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       vld_out_0, vld_out_1, vld_out_2, busy, error;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte;

  router_top dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld_of(input int p);
    case (p)
      0: return vld_out_0;
      1: return vld_out_1;
      default: return vld_out_2;
    endcase
  endfunction

  function automatic logic [7:0] dout_of(input int p);
    case (p)
      0: return data_out_0;
      1: return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic set_rd(input int p, input logic v);
    case (p)
      0: read_enb_0 = v;
      1: read_enb_1 = v;
      default: read_enb_2 = v;
    endcase
  endtask

  // byte is taken on a rising edge only when busy was low before that edge
  task automatic send_byte(input logic [7:0] b, input logic v);
    int   waited = 0;
    logic was_busy;
    data_in   = b;
    pkt_valid = v;
    do begin
      was_busy = busy;
      @(posedge clock);
      @(negedge clock);
      waited++;
    end while (was_busy && waited < 300);
    if (was_busy) check("send_timeout", 32'(was_busy), 32'd0);
  endtask

  task automatic send_packet(input logic [1:0] addr, input logic [5:0] len, input logic corrupt);
    logic [7:0] hdr, par, b;
    hdr = {len, addr};
    par = hdr;
    exp_q.push_back(hdr);
    send_byte(hdr, 1'b1);
    check("err_clr_on_hdr", 32'(error), 32'd0);
    for (int i = 0; i < int'(len); i++) begin
      b   = 8'($urandom);
      par = par ^ b;
      exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    if (corrupt) par = par ^ 8'h01;
    exp_q.push_back(par);
    send_byte(par, 1'b0);
  endtask

  task automatic wait_idle(input logic exp_err);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
    check("error_flag", 32'(error), 32'(exp_err));
  endtask

  task automatic drain(input int p, input int n);
    int         got = 0;
    int         cyc = 0;
    logic       prev;
    logic [7:0] e;
    set_rd(p, 1'b1);
    prev = vld_of(p);
    while (got < n && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (prev) begin
        e = exp_q.pop_front();
        check($sformatf("port%0d_byte%0d", p, got), 32'(dout_of(p)), 32'(e));
        last_byte = e;
        got++;
      end
      prev = vld_of(p);
    end
    set_rd(p, 1'b0);
    if (got < n) check($sformatf("drain%0d_count", p), 32'(got), 32'(n));
    exp_q.delete();
    check($sformatf("port%0d_empty_after", p), 32'(vld_of(p)), 32'd0);
  endtask

  task automatic check_others(input int p);
    for (int q = 0; q < 3; q++)
      if (q != p) check($sformatf("port%0d_quiet", q), 32'(vld_of(q)), 32'd0);
  endtask

  initial begin
    logic [1:0] ra;
    logic [5:0] rl;
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("rst_vld0", 32'(vld_out_0), 32'd0);
    check("rst_vld1", 32'(vld_out_1), 32'd0);
    check("rst_vld2", 32'(vld_out_2), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dout0", 32'(data_out_0), 32'd0);
    check("rst_dout1", 32'(data_out_1), 32'd0);
    check("rst_dout2", 32'(data_out_2), 32'd0);

    // length-8 packet to each port, drained after parity
    for (int p = 0; p < 3; p++) begin
      send_packet(2'(p), 6'd8, 1'b0);
      wait_idle(1'b0);
      check($sformatf("port%0d_vld_rise", p), 32'(vld_of(p)), 32'd1);
      check_others(p);
      drain(p, 10);
    end

    // reading an empty FIFO keeps the last byte
    set_rd(2, 1'b1);
    repeat (3) @(negedge clock);
    check("empty_read_hold", 32'(data_out_2), 32'(last_byte));
    check("empty_read_vld", 32'(vld_out_2), 32'd0);
    set_rd(2, 1'b0);

    // address 3 header is ignored
    data_in = 8'h0B; pkt_valid = 1'b1;
    @(negedge clock);
    pkt_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("addr3_busy", 32'(busy), 32'd0);
    check("addr3_vld", 32'({vld_out_0, vld_out_1, vld_out_2}), 32'd0);

    // corrupted parity, then a good packet clears the flag at its header
    send_packet(2'd1, 6'd3, 1'b1);
    wait_idle(1'b1);
    drain(1, 5);
    send_packet(2'd1, 6'd2, 1'b0);
    wait_idle(1'b0);
    drain(1, 4);

    // minimum length
    send_packet(2'd0, 6'd1, 1'b0);
    wait_idle(1'b0);
    drain(0, 3);

    // length 20 to port 1: FIFO fills, busy holds until reads start
    fork
      send_packet(2'd1, 6'd20, 1'b0);
      begin
        repeat (22) @(negedge clock);
        check("full_busy_held", 32'(busy), 32'd1);
        check("full_vld1", 32'(vld_out_1), 32'd1);
        drain(1, 22);
      end
    join
    wait_idle(1'b0);

    // maximum length with concurrent reading
    fork
      send_packet(2'd0, 6'd63, 1'b0);
      drain(0, 65);
    join
    wait_idle(1'b0);

    // unread packet on port 2 gets flushed by the timeout
    send_packet(2'd2, 6'd4, 1'b0);
    wait_idle(1'b0);
    repeat (8) @(negedge clock);
    check("tmo_vld2_before", 32'(vld_out_2), 32'd1);
    repeat (25) @(negedge clock);
    check("tmo_vld2_flushed", 32'(vld_out_2), 32'd0);
    check("tmo_dout2_cleared", 32'(data_out_2), 32'd0);
    exp_q.delete();
    send_packet(2'd2, 6'd5, 1'b0);
    wait_idle(1'b0);
    drain(2, 7);

    // randomized packets
    for (int k = 0; k < 4; k++) begin
      ra = 2'($urandom_range(0, 2));
      rl = 6'($urandom_range(1, 12));
      send_packet(ra, rl, 1'b0);
      wait_idle(1'b0);
      check_others(int'(ra));
      drain(int'(ra), int'(rl) + 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
